// File: rtl/egress_packet_arbiter_if.sv
// Handshake bundle between the two egress sources, the arbiter and the packet constructor.
interface egress_packet_arbiter_if;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        ready_in;
  logic        last_in;
  logic [31:0] cycles_in;
  logic        cycles_valid;
  logic        cycles_ready;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        ready_out;
  logic        last_out;

  modport slave (
    input  data_in, valid_in, last_in, cycles_in, cycles_valid, ready_out,
    output ready_in, cycles_ready, data_out, valid_out, last_out
  );

  modport master (
    output data_in, valid_in, last_in, cycles_in, cycles_valid, ready_out,
    input  ready_in, cycles_ready, data_out, valid_out, last_out
  );
endinterface

// File: rtl/egress_packet_arbiter.sv
// Packet-granular round-robin arbiter merging processed data packets and 5-byte
// cycle-count reports (tag + big-endian count) onto one byte-wide egress stream.
module egress_packet_arbiter #(
  parameter logic [7:0] CYCLE_TAG = 8'hC1
) (
  input logic                    clock,
  input logic                    reset,
  egress_packet_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] CYCLES = 2'd2;

  logic [1:0]  r_state;
  logic        r_last_grant;
  logic [2:0]  r_byte_idx;
  logic [31:0] r_count_reg;

  logic       w_grant_data;
  logic       w_grant_cycles;
  logic [7:0] w_report_byte;

  // On a tie, grant the source opposite the one served last.
  assign w_grant_data   = (r_state == IDLE) && bus.valid_in &&
                          (!bus.cycles_valid || r_last_grant);
  assign w_grant_cycles = (r_state == IDLE) && bus.cycles_valid &&
                          (!bus.valid_in || !r_last_grant);

  always_comb begin
    w_report_byte = '0;
    case (r_byte_idx)
      3'd0:    w_report_byte = CYCLE_TAG;
      3'd1:    w_report_byte = r_count_reg[31:24];
      3'd2:    w_report_byte = r_count_reg[23:16];
      3'd3:    w_report_byte = r_count_reg[15:8];
      3'd4:    w_report_byte = r_count_reg[7:0];
      default: w_report_byte = '0;
    endcase
  end

  always_comb begin
    bus.data_out     = '0;
    bus.valid_out    = 1'b0;
    bus.last_out     = 1'b0;
    bus.ready_in     = 1'b0;
    bus.cycles_ready = 1'b0;
    case (r_state)
      IDLE: begin
        // Reset holds the FSM in IDLE; gating keeps the accept pulse low too.
        bus.cycles_ready = w_grant_cycles && reset;
      end
      DATA: begin
        bus.data_out  = bus.data_in;
        bus.valid_out = bus.valid_in;
        bus.last_out  = bus.last_in;
        bus.ready_in  = bus.ready_out;
      end
      CYCLES: begin
        bus.data_out  = w_report_byte;
        bus.valid_out = 1'b1;
        bus.last_out  = (r_byte_idx == 3'd4);
      end
      default: begin
        bus.data_out = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_byte_idx   <= '0;
      r_count_reg  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_data) begin
            r_state      <= DATA;
            r_last_grant <= 1'b0;
          end else if (w_grant_cycles) begin
            r_state      <= CYCLES;
            r_last_grant <= 1'b1;
            r_byte_idx   <= '0;
            r_count_reg  <= bus.cycles_in;
          end
        end
        DATA: begin
          if (bus.valid_in && bus.ready_out && bus.last_in)
            r_state <= IDLE;
        end
        CYCLES: begin
          if (bus.ready_out) begin
            if (r_byte_idx == 3'd4)
              r_state <= IDLE;
            else
              r_byte_idx <= r_byte_idx + 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_egress_packet_arbiter.sv
// Randomized bench for egress_packet_arbiter against a packet-level round-robin model.
module tb_egress_packet_arbiter;

  localparam logic [7:0] TAG = 8'hC1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  egress_packet_arbiter_if bif ();

  egress_packet_arbiter #(.CYCLE_TAG(TAG)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [8:0]  dq[$];
  logic [31:0] cq[$];
  logic [8:0]  eq[$];

  logic d_done = 1'b0;
  logic c_done = 1'b0;
  int   bubble_pct = 0;
  int   ready_pct  = 100;

  logic       m_busy = 1'b0;
  logic       m_src  = 1'b0;
  logic       m_prev = 1'b1;
  int         sent   = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_do = '0;
  logic       prev_lo = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(input int len);
    for (int i = 0; i < len; i++)
      dq.push_back({(i == len - 1), 8'($urandom)});
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_valid_out"}, bif.valid_out, 0);
    check_eq({tag, "_last_out"},  bif.last_out,  0);
    check_eq({tag, "_data_out"},  bif.data_out,  0);
    check_eq({tag, "_ready_in"},  bif.ready_in,  0);
  endtask

  task automatic step();
    logic [8:0]  tmp9;
    logic [31:0] tmp32;
    logic        grant_valid;
    logic        grant;
    logic        was_busy;
    @(negedge clock);
    #1;
    if (d_done) begin
      tmp9 = dq.pop_front();
      bif.valid_in = 1'b0;
      d_done = 1'b0;
    end
    if (c_done) begin
      tmp32 = cq.pop_front();
      c_done = 1'b0;
    end
    if (!bif.valid_in && dq.size() > 0 && $urandom_range(99) >= bubble_pct) begin
      bif.valid_in = 1'b1;
      bif.data_in  = dq[0][7:0];
      bif.last_in  = dq[0][8];
    end else if (!bif.valid_in) begin
      bif.data_in = 8'($urandom);
      bif.last_in = 1'($urandom);
    end
    bif.cycles_valid = (cq.size() > 0);
    bif.cycles_in    = (cq.size() > 0) ? cq[0] : $urandom;
    bif.ready_out    = ($urandom_range(99) < ready_pct);
    #1;
    was_busy = m_busy;
    if (!m_busy) begin
      check_idle_outputs("idle");
      grant_valid = bif.valid_in || bif.cycles_valid;
      if (bif.valid_in && bif.cycles_valid) grant = ~m_prev;
      else grant = bif.cycles_valid;
      check_eq("cycles_ready_grant", bif.cycles_ready, grant_valid && grant);
      if (grant_valid) begin
        m_busy = 1'b1;
        m_src  = grant;
        m_prev = grant;
        sent   = 0;
        if (grant) begin
          eq.push_back({1'b0, TAG});
          eq.push_back({1'b0, cq[0][31:24]});
          eq.push_back({1'b0, cq[0][23:16]});
          eq.push_back({1'b0, cq[0][15:8]});
          eq.push_back({1'b1, cq[0][7:0]});
        end else begin
          for (int i = 0; i < dq.size(); i++) begin
            eq.push_back(dq[i]);
            if (dq[i][8]) break;
          end
        end
      end
    end else begin
      check_eq("cycles_ready_busy", bif.cycles_ready, 0);
      if (!m_src) begin
        check_eq("ready_in_mirror", bif.ready_in,  bif.ready_out);
        check_eq("data_pass",       bif.data_out,  bif.data_in);
        check_eq("valid_pass",      bif.valid_out, bif.valid_in);
        check_eq("last_pass",       bif.last_out,  bif.last_in);
      end else begin
        check_eq("report_valid",    bif.valid_out, 1);
        check_eq("report_ready_in", bif.ready_in,  0);
      end
      if (prev_stall) begin
        check_eq("stall_data", bif.data_out, prev_do);
        check_eq("stall_last", bif.last_out, prev_lo);
      end
      if (bif.valid_out && bif.ready_out) begin
        check_eq("egress_expected", (eq.size() > 0), 1);
        if (eq.size() > 0) begin
          tmp9 = eq.pop_front();
          check_eq("egress_byte", bif.data_out, tmp9[7:0]);
          check_eq("egress_last", bif.last_out, tmp9[8]);
          sent++;
          if (tmp9[8]) m_busy = 1'b0;
        end
      end
    end
    prev_stall = was_busy && bif.valid_out && !bif.ready_out;
    prev_do    = bif.data_out;
    prev_lo    = bif.last_out;
    if (bif.valid_in && bif.ready_in) d_done = 1'b1;
    if (bif.cycles_valid && bif.cycles_ready) c_done = 1'b1;
  endtask

  task automatic drain(input int max_cycles);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      done = (dq.size() == 0) && (cq.size() == 0) && (eq.size() == 0) &&
             !m_busy && !d_done && !c_done;
      if (done) break;
      step();
    end
    done = (dq.size() == 0) && (cq.size() == 0) && (eq.size() == 0) &&
           !m_busy && !d_done && !c_done;
    check_eq("drain_done", done, 1);
    step();
  endtask

  initial begin
    bif.data_in      = '0;
    bif.valid_in     = 1'b0;
    bif.last_in      = 1'b0;
    bif.cycles_in    = 32'h1234_5678;
    bif.cycles_valid = 1'b1;
    bif.ready_out    = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    check_idle_outputs("reset");
    check_eq("reset_cycles_ready", bif.cycles_ready, 0);
    bif.cycles_valid = 1'b0;
    @(negedge clock);
    #1 reset = 1'b1;

    // Both sources pending from reset: data first, then strict alternation.
    bubble_pct = 0;
    ready_pct  = 100;
    for (int i = 0; i < 3; i++) begin
      push_pkt(3);
      cq.push_back($urandom);
    end
    drain(200);

    dq.push_back({1'b0, 8'h10});
    dq.push_back({1'b0, 8'h11});
    dq.push_back({1'b1, 8'h12});
    drain(50);

    cq.push_back(32'h0102_0304);
    drain(50);

    bubble_pct = 30;
    ready_pct  = 60;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) == 0 && dq.size() < 12) push_pkt($urandom_range(1, 5));
      if ($urandom_range(9) == 0 && cq.size() < 2) cq.push_back($urandom);
      step();
    end
    drain(3000);

    // Count arrives mid data packet, then a single-byte packet.
    bubble_pct = 0;
    ready_pct  = 100;
    push_pkt(4);
    step();
    step();
    cq.push_back(32'hCAFE_F00D);
    drain(100);
    dq.push_back({1'b1, 8'hAA});
    drain(50);

    // Reset while the report is at byte index 2.
    cq.push_back(32'hDEAD_BEEF);
    for (int i = 0; i < 20; i++) begin
      if (m_busy && m_src && sent == 2) break;
      step();
    end
    check_eq("reached_byte2", (m_busy && m_src && sent == 2), 1);
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check_idle_outputs("midreset");
    check_eq("midreset_cycles_ready", bif.cycles_ready, 0);
    dq.delete();
    cq.delete();
    eq.delete();
    m_busy = 1'b0;
    m_prev = 1'b1;
    d_done = 1'b0;
    c_done = 1'b0;
    prev_stall = 1'b0;
    bif.valid_in     = 1'b0;
    bif.cycles_valid = 1'b0;
    @(negedge clock);
    #1 reset = 1'b1;
    dq.push_back({1'b0, 8'h55});
    dq.push_back({1'b1, 8'h66});
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
